// File: rtl/term_writer.sv
// Serial-terminal writer: turns the UART RX byte stream into text RAM writes, tracks the cursor, scrolls by row offset.
// Latency: write issued the cycle after the handshake; tready only in IDLE, so at most one byte per two cycles and none during INIT/CLEAR.
module term_writer #(
    parameter int COLS   = 80,
    parameter int ROWS   = 30,
    parameter int COL_W  = 7,
    parameter int ROW_W  = 5,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [ROW_W-1:0]  row_offset,
    output logic [COL_W-1:0]  cursor_col,
    output logic [ROW_W-1:0]  cursor_row,
    output logic              busy
);

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_PUT, ST_CLEAR} state_t;

    localparam logic [ADDR_W:0]   CELLS    = (ADDR_W+1)'(COLS*ROWS);
    localparam logic [ADDR_W:0]   LINE     = (ADDR_W+1)'(COLS);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [COL_W-1:0]  LAST_COL = COL_W'(COLS-1);
    localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(ROWS-1);
    localparam logic [7:0]        SPACE    = 8'h20;

    // Physical cell address of a logical (row, col) under a given scroll offset.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                    input logic [ROW_W-1:0] off,
                                                    input logic [COL_W-1:0] col);
        logic [ROW_W:0] sum;
        sum = {1'b0, row} + {1'b0, off};
        if (sum >= (ROW_W+1)'(ROWS))
            sum = sum - (ROW_W+1)'(ROWS);
        return ADDR_W'(sum) * ADDR_W'(COLS) + ADDR_W'(col);
    endfunction

    state_t              state, state_nxt;
    logic [ADDR_W:0]     cnt, cnt_nxt;
    logic [7:0]          byte_q, byte_nxt;
    logic [ADDR_W-1:0]   clr_base, base_nxt;
    logic [COL_W-1:0]    col_nxt;
    logic [ROW_W-1:0]    row_nxt, off_nxt;
    logic                wr_en_nxt;
    logic [ADDR_W-1:0]   wr_addr_nxt;
    logic [7:0]          wr_data_nxt;
    logic                newline;

    assign s_axis_tready = (state == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_INIT;
            cnt        <= '0;
            byte_q     <= '0;
            clr_base   <= '0;
            cursor_col <= '0;
            cursor_row <= '0;
            row_offset <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            byte_q     <= byte_nxt;
            clr_base   <= base_nxt;
            cursor_col <= col_nxt;
            cursor_row <= row_nxt;
            row_offset <= off_nxt;
            wr_en      <= wr_en_nxt;
            wr_addr    <= wr_addr_nxt;
            wr_data    <= wr_data_nxt;
            busy       <= (state_nxt == ST_INIT) || (state_nxt == ST_CLEAR);
        end
    end

    // Write strobes are computed one cycle ahead so they line up with the state that owns them.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        byte_nxt    = byte_q;
        base_nxt    = clr_base;
        col_nxt     = cursor_col;
        row_nxt     = cursor_row;
        off_nxt     = row_offset;
        wr_en_nxt   = 1'b0;
        wr_addr_nxt = wr_addr;
        wr_data_nxt = wr_data;
        newline     = 1'b0;
        case (state)
            ST_INIT: begin
                if (cnt < CELLS) begin
                    wr_en_nxt   = 1'b1;
                    wr_addr_nxt = cnt[ADDR_W-1:0];
                    wr_data_nxt = SPACE;
                    cnt_nxt     = cnt + CNT_ONE;
                end else begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            end
            ST_IDLE: begin
                if (s_axis_tvalid) begin
                    byte_nxt  = s_axis_tdata;
                    state_nxt = ST_PUT;
                    if (s_axis_tdata >= 8'h20 && s_axis_tdata <= 8'h7E) begin
                        wr_en_nxt   = 1'b1;
                        wr_addr_nxt = cell_addr(cursor_row, row_offset, cursor_col);
                        wr_data_nxt = s_axis_tdata;
                    end
                end
            end
            ST_PUT: begin
                if (byte_q >= 8'h20 && byte_q <= 8'h7E) begin
                    if (cursor_col == LAST_COL) begin
                        col_nxt = '0;
                        newline = 1'b1;
                    end else begin
                        col_nxt = cursor_col + COL_W'(1);
                    end
                end else if (byte_q == 8'h0D) begin
                    col_nxt = '0;
                end else if (byte_q == 8'h0A) begin
                    newline = 1'b1;
                end else if (byte_q == 8'h08 && cursor_col != '0) begin
                    col_nxt = cursor_col - COL_W'(1);
                end
                state_nxt = ST_IDLE;
                if (newline) begin
                    if (cursor_row != LAST_ROW) begin
                        row_nxt = cursor_row + ROW_W'(1);
                    end else begin
                        // Scroll: the old top line becomes the new bottom line and is blanked.
                        off_nxt     = (row_offset == LAST_ROW) ? '0 : row_offset + ROW_W'(1);
                        base_nxt    = cell_addr(LAST_ROW, off_nxt, '0);
                        state_nxt   = ST_CLEAR;
                        wr_en_nxt   = 1'b1;
                        wr_addr_nxt = base_nxt;
                        wr_data_nxt = SPACE;
                        cnt_nxt     = CNT_ONE;
                    end
                end
            end
            ST_CLEAR: begin
                if (cnt < LINE) begin
                    wr_en_nxt   = 1'b1;
                    wr_addr_nxt = clr_base + cnt[ADDR_W-1:0];
                    wr_data_nxt = SPACE;
                    cnt_nxt     = cnt + CNT_ONE;
                end else begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = ST_INIT;
        endcase
    end

endmodule

// File: tb/tb_term_writer.sv
// Directed bench: an 80x30 instance for INIT, writes, control codes and line wrap; a 4x3 instance for scroll and reset-in-CLEAR.
module tb_term_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic [7:0]  b_tdata, s_tdata;
    logic        b_tvalid, s_tvalid, b_tready, s_tready;
    logic        b_wr_en, s_wr_en, b_busy, s_busy;
    logic [11:0] b_wr_addr;
    logic [3:0]  s_wr_addr;
    logic [7:0]  b_wr_data, s_wr_data;
    logic [4:0]  b_row_offset, b_row;
    logic [6:0]  b_col;
    logic [1:0]  s_row_offset, s_row, s_col;

    int checks = 0;
    int errors = 0;

    localparam logic [7:0] CTL_B   [4] = '{8'h0D, 8'h0A, 8'h08, 8'h07};
    localparam logic [6:0] CTL_COL [4] = '{7'd0, 7'd0, 7'd0, 7'd0};
    localparam logic [4:0] CTL_ROW [4] = '{5'd0, 5'd1, 5'd1, 5'd1};

    term_writer u_big (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(b_tdata), .s_axis_tvalid(b_tvalid), .s_axis_tready(b_tready),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .row_offset(b_row_offset), .cursor_col(b_col), .cursor_row(b_row), .busy(b_busy)
    );

    term_writer #(.COLS(4), .ROWS(3), .COL_W(2), .ROW_W(2), .ADDR_W(4)) u_small (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
        .row_offset(s_row_offset), .cursor_col(s_col), .cursor_row(s_row), .busy(s_busy)
    );

    // Enter at a negedge; returns write outputs seen in the PUT cycle and leaves at the following negedge.
    task automatic send(input bit sm, input logic [7:0] b, output logic we, output logic [11:0] a,
                        output logic [7:0] d, output logic rdy);
        int wait_n;
        wait_n = 0;
        if (sm) begin s_tdata = b; s_tvalid = 1'b1; end
        else    begin b_tdata = b; b_tvalid = 1'b1; end
        while (!(sm ? s_tready : b_tready) && wait_n < 200) begin
            @(negedge clk);
            wait_n++;
        end
        checks++;
        if (wait_n >= 200) begin
            errors++;
            $display("FAIL send_timeout: tready=0 after %0d cycles, required 1", wait_n);
        end
        @(negedge clk);
        we  = sm ? s_wr_en : b_wr_en;
        a   = sm ? {8'h00, s_wr_addr} : b_wr_addr;
        d   = sm ? s_wr_data : b_wr_data;
        rdy = sm ? s_tready : b_tready;
        s_tvalid = 1'b0;
        b_tvalid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int bad, first;
        rst_n = 1'b0; b_tvalid = 1'b0; s_tvalid = 1'b0; b_tdata = '0; s_tdata = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({b_wr_en, b_wr_addr, b_wr_data, b_row_offset, b_col, b_row, b_busy, b_tready} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got en=%b addr=%0d data=%h off=%0d col=%0d row=%0d busy=%b rdy=%b, required all 0",
                     b_wr_en, b_wr_addr, b_wr_data, b_row_offset, b_col, b_row, b_busy, b_tready);
        end
        rst_n = 1'b1;
        bad = 0; first = -1;
        for (int i = 0; i < 2400; i++) begin
            @(negedge clk);
            if (b_wr_en !== 1'b1 || b_wr_addr !== i[11:0] || b_wr_data !== 8'h20 ||
                b_tready !== 1'b0 || b_busy !== 1'b1) begin
                if (bad == 0) first = i;
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL init_writes: %0d bad cycles (first at %0d), required 0", bad, first);
        end
        @(negedge clk);
        checks++;
        if (b_tready !== 1'b1 || b_wr_en !== 1'b0 || b_busy !== 1'b0) begin
            errors++;
            $display("FAIL init_done: rdy=%b en=%b busy=%b, required 1 0 0", b_tready, b_wr_en, b_busy);
        end
        checks++;
        if (b_row_offset !== 5'd0 || b_col !== 7'd0 || b_row !== 5'd0) begin
            errors++;
            $display("FAIL init_cursor: off=%0d col=%0d row=%0d, required 0 0 0", b_row_offset, b_col, b_row);
        end
    endtask

    task automatic test_back_to_back();
        b_tdata = 8'h41; b_tvalid = 1'b1;
        @(negedge clk);
        checks++;
        if (b_wr_en !== 1'b1 || b_wr_addr !== 12'd0 || b_wr_data !== 8'h41 || b_tready !== 1'b0) begin
            errors++;
            $display("FAIL write_A: en=%b addr=%0d data=%h rdy=%b, required 1 0 41 0", b_wr_en, b_wr_addr, b_wr_data, b_tready);
        end
        b_tdata = 8'h42;
        @(negedge clk);
        checks++;
        if (b_wr_en !== 1'b0 || b_tready !== 1'b1 || b_col !== 7'd1) begin
            errors++;
            $display("FAIL gap_after_A: en=%b rdy=%b col=%0d, required 0 1 1", b_wr_en, b_tready, b_col);
        end
        @(negedge clk);
        checks++;
        if (b_wr_en !== 1'b1 || b_wr_addr !== 12'd1 || b_wr_data !== 8'h42 || b_tready !== 1'b0) begin
            errors++;
            $display("FAIL write_B: en=%b addr=%0d data=%h rdy=%b, required 1 1 42 0", b_wr_en, b_wr_addr, b_wr_data, b_tready);
        end
        b_tvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (b_col !== 7'd2 || b_row !== 5'd0 || b_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL cursor_after_AB: col=%0d row=%0d en=%b, required 2 0 0", b_col, b_row, b_wr_en);
        end
    endtask

    task automatic test_control();
        logic we, rdy;
        logic [11:0] a;
        logic [7:0] d;
        for (int i = 0; i < 3; i++) send(1'b0, 8'h43 + 8'(i), we, a, d, rdy);
        checks++;
        if (b_col !== 7'd5) begin
            errors++;
            $display("FAIL cursor_col5: col=%0d, required 5", b_col);
        end
        for (int i = 0; i < 4; i++) begin
            send(1'b0, CTL_B[i], we, a, d, rdy);
            checks++;
            if (we !== 1'b0 || b_col !== CTL_COL[i] || b_row !== CTL_ROW[i]) begin
                errors++;
                $display("FAIL ctrl_%h: en=%b col=%0d row=%0d, required 0 %0d %0d",
                         CTL_B[i], we, b_col, b_row, CTL_COL[i], CTL_ROW[i]);
            end
        end
        send(1'b0, 8'h5A, we, a, d, rdy);
        checks++;
        if (we !== 1'b1 || a !== 12'd80 || d !== 8'h5A || b_col !== 7'd1) begin
            errors++;
            $display("FAIL write_Z_row1: en=%b addr=%0d data=%h col=%0d, required 1 80 5a 1", we, a, d, b_col);
        end
        send(1'b0, 8'h08, we, a, d, rdy);
        checks++;
        if (we !== 1'b0 || b_col !== 7'd0 || b_row !== 5'd1) begin
            errors++;
            $display("FAIL bs_from_col1: en=%b col=%0d row=%0d, required 0 0 1", we, b_col, b_row);
        end
    endtask

    task automatic test_line_wrap();
        logic we, rdy;
        logic [11:0] a;
        logic [7:0] d, ch;
        int bad;
        bad = 0;
        for (int i = 0; i < 80; i++) begin
            ch = 8'h30 + 8'(i % 10);
            send(1'b0, ch, we, a, d, rdy);
            if (we !== 1'b1 || a !== 12'(80 + i) || d !== ch || rdy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL wrap_writes: %0d bad writes, required 0", bad);
        end
        checks++;
        if (a !== 12'd159) begin
            errors++;
            $display("FAIL wrap_last_addr: addr=%0d, required 159", a);
        end
        checks++;
        if (b_col !== 7'd0 || b_row !== 5'd2 || b_row_offset !== 5'd0 || b_busy !== 1'b0 || b_tready !== 1'b1) begin
            errors++;
            $display("FAIL wrap_cursor: col=%0d row=%0d off=%0d busy=%b rdy=%b, required 0 2 0 0 1",
                     b_col, b_row, b_row_offset, b_busy, b_tready);
        end
    endtask

    task automatic test_scroll();
        logic we, rdy;
        logic [11:0] a;
        logic [7:0] d;
        send(1'b1, 8'h0A, we, a, d, rdy);
        send(1'b1, 8'h0A, we, a, d, rdy);
        checks++;
        if (s_row !== 2'd2 || s_row_offset !== 2'd0 || s_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL two_lf: row=%0d off=%0d en=%b, required 2 0 0", s_row, s_row_offset, s_wr_en);
        end
        send(1'b1, 8'h0A, we, a, d, rdy);
        checks++;
        if (we !== 1'b0 || s_row_offset !== 2'd1 || s_row !== 2'd2 || s_busy !== 1'b1) begin
            errors++;
            $display("FAIL scroll_lf: put_en=%b off=%0d row=%0d busy=%b, required 0 1 2 1", we, s_row_offset, s_row, s_busy);
        end
        for (int j = 0; j < 4; j++) begin
            if (j != 0) @(negedge clk);
            checks++;
            if (s_wr_en !== 1'b1 || s_wr_addr !== 4'(j) || s_wr_data !== 8'h20 || s_tready !== 1'b0) begin
                errors++;
                $display("FAIL clear_col%0d: en=%b addr=%0d data=%h rdy=%b, required 1 %0d 20 0",
                         j, s_wr_en, s_wr_addr, s_wr_data, s_tready, j);
            end
        end
        @(negedge clk);
        checks++;
        if (s_tready !== 1'b1 || s_wr_en !== 1'b0 || s_busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_done: rdy=%b en=%b busy=%b, required 1 0 0", s_tready, s_wr_en, s_busy);
        end
        send(1'b1, 8'h58, we, a, d, rdy);
        checks++;
        if (we !== 1'b1 || a !== 12'd0 || d !== 8'h58 || s_col !== 2'd1) begin
            errors++;
            $display("FAIL write_X: en=%b addr=%0d data=%h col=%0d, required 1 0 58 1", we, a, d, s_col);
        end
    endtask

    task automatic test_reset_mid_clear();
        logic we, rdy;
        logic [11:0] a;
        logic [7:0] d;
        int bad;
        send(1'b1, 8'h0A, we, a, d, rdy);
        checks++;
        if (s_row_offset !== 2'd2 || s_wr_en !== 1'b1 || s_wr_addr !== 4'd4) begin
            errors++;
            $display("FAIL scroll2_clear: off=%0d en=%b addr=%0d, required 2 1 4", s_row_offset, s_wr_en, s_wr_addr);
        end
        @(negedge clk);
        #2;
        s_tdata = 8'h41; s_tvalid = 1'b1; rst_n = 1'b0;
        #1;
        checks++;
        if ({s_wr_en, s_wr_addr, s_wr_data, s_row_offset, s_col, s_row, s_busy, s_tready} !== '0) begin
            errors++;
            $display("FAIL async_reset: en=%b addr=%0d data=%h off=%0d col=%0d row=%0d busy=%b rdy=%b, required all 0",
                     s_wr_en, s_wr_addr, s_wr_data, s_row_offset, s_col, s_row, s_busy, s_tready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (s_wr_en !== 1'b1 || s_wr_addr !== 4'(i) || s_wr_data !== 8'h20 || s_tready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reinit_writes: %0d bad cycles, required 0", bad);
        end
        @(negedge clk);
        checks++;
        if (s_tready !== 1'b1 || s_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL reinit_done: rdy=%b en=%b, required 1 0", s_tready, s_wr_en);
        end
        @(negedge clk);
        checks++;
        if (s_wr_en !== 1'b1 || s_wr_addr !== 4'd0 || s_wr_data !== 8'h41 || s_tready !== 1'b0) begin
            errors++;
            $display("FAIL held_byte_after_init: en=%b addr=%0d data=%h rdy=%b, required 1 0 41 0",
                     s_wr_en, s_wr_addr, s_wr_data, s_tready);
        end
        s_tvalid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_control();
        test_line_wrap();
        test_scroll();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
